// File: rtl/fir2_postproc_if.sv
// fir2_postproc handshake bundle: sub-filter triple in, filtered pair out.
// Ascending ranges keep the MSB at index 0 to match the sub-filter outputs.
interface fir2_postproc_if #(
  parameter int AWIDTH  = 37,
  parameter int DWIDTH  = 16,
  parameter int DDWIDTH = 2*DWIDTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [0:AWIDTH-1] p0;
  logic signed [0:AWIDTH-1] p1;
  logic signed [0:AWIDTH-1] p2;
  logic                     out_valid;
  logic                     out_ready;
  logic        [0:DDWIDTH-1] data_out;
  logic        [1:0]        out_sat;

  // upstream/testbench side
  modport master (
    output in_valid, p0, p1, p2, out_ready,
    input  in_ready, out_valid, data_out, out_sat
  );

  // block side
  modport slave (
    input  in_valid, p0, p1, p2, out_ready,
    output in_ready, out_valid, data_out, out_sat
  );
endinterface

// File: rtl/fir2_postproc.sv
// 2-parallel FFA recombination: y0 = p0 + z^-1 p2, y1 = p1 - p0 - p2.
// Two-stage skid-free pipeline: s1 holds exact sums, s2 holds rounded and
// saturated samples. z^-1 advances per accepted triple, not per clock.

// Round-half-up by 2^FRAC then clip to a signed DWIDTH sample.
module fir2_postproc_rndsat #(
  parameter int IW     = 39,
  parameter int DWIDTH = 16,
  parameter int FRAC   = 15
) (
  input  logic signed [IW-1:0]  din,
  output logic        [DWIDTH-1:0] dout,
  output logic                  sat
);
  localparam logic signed [IW:0] HALF = (IW+1)'(1) << (FRAC - 1);
  localparam logic signed [IW:0] MAXV = (IW+1)'((1 << (DWIDTH - 1)) - 1);
  localparam logic signed [IW:0] MINV = -MAXV - 1;

  logic signed [IW:0] rnd;
  logic signed [IW:0] shf;

  // one extra bit keeps the rounding add from wrapping
  always_comb begin
    rnd  = (IW+1)'(din) + HALF;
    shf  = rnd >>> FRAC;
    dout = shf[DWIDTH-1:0];
    sat  = 1'b0;
    if (shf > MAXV) begin
      dout = MAXV[DWIDTH-1:0];
      sat  = 1'b1;
    end else if (shf < MINV) begin
      dout = MINV[DWIDTH-1:0];
      sat  = 1'b1;
    end
  end
endmodule

module fir2_postproc #(
  parameter int NR_STAGES = 32,
  parameter int DWIDTH    = 16,
  parameter int DDWIDTH   = 2*DWIDTH,
  parameter int AWIDTH    = 37,
  parameter int FRAC      = 15
) (
  input  logic            clk,
  input  logic            rst,
  fir2_postproc_if.slave  bus
);
  // Internal sums cover full sub-filter growth even if AWIDTH is set narrow;
  // +2 bits make p1 - p0 - p2 exact.
  localparam int MIN_AW = 2*DWIDTH + 1 + $clog2(NR_STAGES/2);
  localparam int AW_INT = (AWIDTH > MIN_AW) ? AWIDTH : MIN_AW;
  localparam int SW     = AW_INT + 2;
  localparam int LANES  = 2;   // lane 0 = y0 (earlier sample), lane 1 = y1

  logic [2:1]                        vld_pipe_q, vld_pipe_d;  // [1]=s1, [2]=s2
  logic signed [AWIDTH-1:0]          d1_q, d1_d;
  logic [LANES-1:0][SW-1:0]          s1_q, s1_d;
  logic [LANES-1:0][DWIDTH-1:0]      y_q, y_d;
  logic [LANES-1:0]                  sat_q, sat_d;

  logic [LANES-1:0][DWIDTH-1:0]      rs_y;
  logic [LANES-1:0]                  rs_sat;
  logic signed [SW-1:0]              p0_x, p1_x, p2_x, d1_x;
  logic                              accept, advance, in_ready_w;
  logic [DDWIDTH-1:0]                dout_w;

  // stage handshakes: s1 may refill in the same cycle it drains to s2
  assign in_ready_w = !vld_pipe_q[1] || !vld_pipe_q[2] || bus.out_ready;
  assign accept     = bus.in_valid && in_ready_w;
  assign advance    = vld_pipe_q[1] && (!vld_pipe_q[2] || bus.out_ready);

  assign p0_x = SW'(bus.p0);
  assign p1_x = SW'(bus.p1);
  assign p2_x = SW'(bus.p2);
  assign d1_x = SW'(d1_q);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fir2_postproc_rndsat #(.IW(SW), .DWIDTH(DWIDTH), .FRAC(FRAC)) u_rs (
      .din  (s1_q[l]),
      .dout (rs_y[l]),
      .sat  (rs_sat[l])
    );
  end

  // next-state for both stages and the per-accept delay line
  always_comb begin
    vld_pipe_d = vld_pipe_q;
    d1_d       = d1_q;
    s1_d       = s1_q;
    y_d        = y_q;
    sat_d      = sat_q;
    if (advance) begin
      vld_pipe_d[2] = 1'b1;
      y_d           = rs_y;
      sat_d         = rs_sat;
    end else if (bus.out_ready) begin
      vld_pipe_d[2] = 1'b0;
    end
    if (accept) begin
      vld_pipe_d[1] = 1'b1;
      s1_d[0]       = p0_x + d1_x;
      s1_d[1]       = p1_x - p0_x - p2_x;
      d1_d          = bus.p2;
    end else if (advance) begin
      vld_pipe_d[1] = 1'b0;
    end
  end

  // state registers; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      d1_q       <= '0;
      s1_q       <= '0;
      y_q        <= '0;
      sat_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      d1_q       <= d1_d;
      s1_q       <= s1_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
    end
  end

  assign dout_w        = {y_q[0], y_q[1]};
  assign bus.data_out  = dout_w;
  assign bus.out_sat   = {sat_q[0], sat_q[1]};
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.in_ready  = in_ready_w;
endmodule

// File: tb/tb_fir2_postproc.sv
// Directed + random bench for fir2_postproc with an expected-result queue.
module tb_fir2_postproc;
  logic clk;
  logic rst;

  fir2_postproc_if #(.AWIDTH(37), .DWIDTH(16), .DDWIDTH(32)) bus();

  fir2_postproc dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] y0;
    logic signed [15:0] y1;
    logic [1:0]         sat;
  } exp_t;

  exp_t   sb[$];
  longint d1m;
  longint cp0, cp1, cp2;
  int     n_cmp, n_err, n_acc, n_pop;
  logic   acc_s, ov_s, ir_s;
  logic signed [15:0] last_y0, last_y1;
  logic [1:0]         last_sat;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // golden rounding: floor((s + 0.5 LSB) / 2^15) via integer division, then clip
  function automatic longint rndsat(longint s, output bit sat);
    longint t, q;
    t = s + 16384;
    q = t / 32768;
    if (t < 0 && (t % 32768) != 0) q = q - 1;
    sat = 1'b0;
    if (q > 32767)  begin q = 32767;  sat = 1'b1; end
    if (q < -32768) begin q = -32768; sat = 1'b1; end
    return q;
  endfunction

  task automatic drive(logic v, longint a, longint b, longint c);
    bus.in_valid = v;
    cp0 = a; cp1 = b; cp2 = c;
    bus.p0 = 37'(a);
    bus.p1 = 37'(b);
    bus.p2 = 37'(c);
  endtask

  // mid-cycle sampling: pop/compare on output handshake, push on input accept
  task automatic mid();
    exp_t e;
    logic [0:31] dout;
    bit s0, s1;
    #3;
    acc_s = bus.in_valid && bus.in_ready;
    ov_s  = bus.out_valid;
    ir_s  = bus.in_ready;
    if (rst) return;
    if (bus.out_valid && bus.out_ready) begin
      dout = bus.data_out;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("y0", $signed(dout[0:15]), e.y0);
        chk("y1", $signed(dout[16:31]), e.y1);
        chk("sat", bus.out_sat, e.sat);
      end
      last_y0  = dout[0:15];
      last_y1  = dout[16:31];
      last_sat = bus.out_sat;
      n_pop++;
    end
    if (acc_s) begin
      e.y0  = 16'(rndsat(cp0 + d1m, s0));
      e.y1  = 16'(rndsat(cp1 - cp0 - cp2, s1));
      e.sat = {s0, s1};
      sb.push_back(e);
      d1m = cp2;
      n_acc++;
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int bound);
    int c;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    c = 0;
    while ((sb.size() != 0 || bus.out_valid) && c < bound) begin
      mid();
      edge_();
      c++;
    end
    chk("drain_done", c < bound, 1);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    mid();
    edge_();
    rst = 1'b0;
    sb.delete();
    d1m = 0;
  endtask

  function automatic longint rnd_p();
    longint v;
    v = longint'({$urandom, $urandom});
    return v >>> (27 + $urandom_range(0, 12));
  endfunction

  longint bp0[3], bp1[3], bp2[3];
  logic [0:31] held;
  int base, k, cyc;

  initial begin
    n_cmp = 0; n_err = 0; n_acc = 0; n_pop = 0; d1m = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0);
    edge_();
    edge_();
    rst = 1'b0;

    // reset state
    mid();
    chk("rst_out_valid", ov_s, 0);
    chk("rst_in_ready", ir_s, 1);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    edge_();

    // single triple, latency 2
    bus.out_ready = 1'b1;
    drive(1, 32768, 98304, 32768);
    mid();
    chk("t1_accept", acc_s, 1);
    edge_();
    bus.in_valid = 1'b0;
    mid();
    chk("t1_lat_p1", ov_s, 0);
    edge_();
    mid();
    chk("t1_lat_p2", ov_s, 1);
    chk("t1_y0", last_y0, 1);
    chk("t1_y1", last_y1, 1);
    chk("t1_sat", last_sat, 0);
    edge_();
    drive(1, 32768, 98304, 32768);
    mid();
    edge_();
    drain(8);
    chk("t1b_y0", last_y0, 2);
    chk("t1b_y1", last_y1, 1);

    // rounding
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 16384, 16384, 0);
    mid(); edge_(); drain(8);
    chk("rnd_pos_y0", last_y0, 1);
    chk("rnd_pos_y1", last_y1, 0);
    drive(1, -16384, -16384, 0);
    mid(); edge_(); drain(8);
    chk("rnd_neg_y0", last_y0, 0);
    chk("rnd_neg_y1", last_y1, 0);

    // saturation both directions
    drive(1, 64'sd2147483648, 0, 0);
    mid(); edge_(); drain(8);
    chk("sat_hi_y0", last_y0, 32767);
    chk("sat_hi_y1", last_y1, -32768);
    chk("sat_hi_f", last_sat, 3);
    drive(1, -64'sd2147483648, 0, 0);
    mid(); edge_(); drain(8);
    chk("sat_lo_y0", last_y0, -32768);
    chk("sat_lo_y1", last_y1, 32767);
    chk("sat_lo_f", last_sat, 3);

    // backpressure: only two triples fit, output holds
    bp0[0] = 100000;  bp1[0] = 5000;    bp2[0] = 70000;
    bp0[1] = -40000;  bp1[1] = 300000;  bp2[1] = 12345;
    bp0[2] = 9999;    bp1[2] = -80000;  bp2[2] = -65536;
    base = n_acc;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      k = n_acc - base;
      drive(1, bp0[k], bp1[k], bp2[k]);
      mid();
      if (i >= 2) chk("bp_in_ready", ir_s, 0);
      if (i == 2) held = bus.data_out;
      if (i > 2) begin
        chk("bp_hold_data", bus.data_out, held);
        chk("bp_hold_valid", ov_s, 1);
      end
      edge_();
    end
    chk("bp_accepted", n_acc - base, 2);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (n_acc - base < 3 && cyc < 10) begin
      k = n_acc - base;
      drive(1, bp0[k], bp1[k], bp2[k]);
      mid();
      edge_();
      cyc++;
    end
    chk("bp_accepted3", n_acc - base, 3);
    drain(10);
    drive(1, 32768, 0, 0);
    mid(); edge_(); drain(8);

    // random streaming
    base = n_acc;
    cyc = 0;
    while (n_acc - base < 100 && cyc < 3000) begin
      if ($urandom_range(0, 9) < 7) drive(1, rnd_p(), rnd_p(), rnd_p());
      else bus.in_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      mid();
      edge_();
      cyc++;
    end
    chk("stream_count", n_acc - base, 100);
    drain(20);

    // mid-stream reset with both stages full
    bus.out_ready = 1'b0;
    drive(1, rnd_p(), rnd_p(), rnd_p());
    mid(); edge_();
    drive(1, rnd_p(), rnd_p(), rnd_p());
    mid(); edge_();
    chk("mr_full_valid", bus.out_valid, 1);
    chk("mr_full_ready", bus.in_ready, 0);
    do_reset();
    bus.out_ready = 1'b1;
    drive(1, 32768, 0, 0);
    mid();
    chk("mr_out_valid", ov_s, 0);
    chk("mr_data_out", bus.data_out, 0);
    chk("mr_in_ready", ir_s, 1);
    edge_();
    drain(8);
    chk("mr_y0", last_y0, 1);
    chk("mr_y1", last_y1, -1);

    chk("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
